// File: rtl/usb_rx_phy_pkg.sv
// Shared types for the low-speed USB receive PHY: pin pair, line-state
// codes and the receive FSM state.
package usb_rx_phy_pkg;

    // Bit 1 = D-, bit 0 = D+
    typedef logic [1:0] d_port_t;

    // Low-speed J/K coding
    localparam d_port_t LS_SE0 = 2'b00;
    localparam d_port_t LS_K   = 2'b01;
    localparam d_port_t LS_J   = 2'b10;
    localparam d_port_t LS_SE1 = 2'b11;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned STUFF_RUN      = 6;
    localparam int unsigned SYNC_MIN_ZEROS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR
    } rx_state_t;

endpackage

// File: rtl/usb_rx_phy_if.sv
// Receive-side bus of the USB PHY.
//   d_i        raw pins into the PHY
//   line_state synchronized pins
//   rx_*       received byte stream and packet framing
//   usb_reset  bus-reset level
// master = PHY side, slave = consumer / pin driver side.
interface usb_rx_phy_if;
    import usb_rx_phy_pkg::*;

    d_port_t    d_i;
    d_port_t    line_state;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_error;
    logic       usb_reset;

    modport master (
        input  d_i,
        output line_state, rx_data, rx_valid, rx_active, rx_eop, rx_error, usb_reset
    );

    modport slave (
        output d_i,
        input  line_state, rx_data, rx_valid, rx_active, rx_eop, rx_error, usb_reset
    );
endinterface

// File: rtl/usb_rx_dpll.sv
// Pin synchronizer and bit-phase recovery.
//   clk, reset  24 MHz clock, async active-high reset
//   d_i         raw pins (asynchronous)
//   line_state  second synchronizer flop
//   sample_stb  one-cycle strobe near mid-bit, aligned with line_state
module usb_rx_dpll
    import usb_rx_phy_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic    clk,
    input  logic    reset,
    input  d_port_t d_i,
    output d_port_t line_state,
    output logic    sample_stb
);
    localparam int unsigned    PH_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(CLKS_PER_BIT / 2 - 1);

    d_port_t         meta_q, meta_d;
    d_port_t         line_q, line_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            stb_q, stb_d;

    // Phase restarts on the clock where line_state takes a new value,
    // so the strobe lands a fixed distance after every transition.
    always_comb begin
        meta_d = d_i;
        line_d = meta_q;
        if (meta_q != line_q || phase_q == PH_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
        stb_d = (phase_d == PH_SAMPLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q  <= LS_J;
            line_q  <= LS_J;
            phase_q <= '0;
            stb_q   <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            line_q  <= line_d;
            phase_q <= phase_d;
            stb_q   <= stb_d;
        end
    end

    assign line_state = line_q;
    assign sample_stb = stb_q;
endmodule

// File: rtl/usb_rx_phy.sv
// Low-speed USB receive PHY: NRZI decode, bit unstuffing, SYNC/EOP framing
// and bus-reset detection on top of usb_rx_dpll.
//   clk, reset  24 MHz clock, async active-high reset
//   bus         usb_rx_phy_if master: d_i in; line_state, rx_data,
//               rx_valid, rx_active, rx_eop, rx_error, usb_reset out
module usb_rx_phy
    import usb_rx_phy_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned RESET_CYCLES = 240000
) (
    input logic          clk,
    input logic          reset,
    usb_rx_phy_if.master bus
);
    localparam int unsigned     SE0_W   = $clog2(RESET_CYCLES + 1);
    localparam logic [SE0_W-1:0] SE0_MAX = SE0_W'(RESET_CYCLES);

    d_port_t ls;
    logic    stb;

    usb_rx_dpll #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_dpll (
        .clk        (clk),
        .reset      (reset),
        .d_i        (bus.d_i),
        .line_state (ls),
        .sample_stb (stb)
    );

    rx_state_t        state_q, state_d;
    logic             prev_k_q, prev_k_d;
    logic [1:0]       zeros_q, zeros_d;
    logic [2:0]       ones_q, ones_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             active_q, active_d;
    logic             eop_q, eop_d;
    logic             error_q, error_d;
    logic             eop_ok_q, eop_ok_d;
    logic             seen_se0_q, seen_se0_d;
    logic [SE0_W-1:0] se0_cnt_q, se0_cnt_d;
    logic             usb_reset_q, usb_reset_d;

    logic is_se0, is_j, is_k, bit_val;
    assign is_se0  = (ls == LS_SE0);
    assign is_j    = (ls == LS_J);
    assign is_k    = (ls == LS_K) || (ls == LS_SE1);
    // NRZI: no transition is a 1
    assign bit_val = (is_k == prev_k_q);

    always_comb begin
        state_d    = state_q;
        prev_k_d   = prev_k_q;
        zeros_d    = zeros_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        active_d   = active_q;
        eop_d      = 1'b0;
        error_d    = 1'b0;
        eop_ok_d   = eop_ok_q;
        seen_se0_d = seen_se0_q;

        // Bus-reset detector, saturating SE0 run length
        if (is_se0) begin
            se0_cnt_d = (se0_cnt_q == SE0_MAX) ? se0_cnt_q : se0_cnt_q + SE0_W'(1);
        end else begin
            se0_cnt_d = '0;
        end
        usb_reset_d = (se0_cnt_d == SE0_MAX);

        if (stb) begin
            if (!is_se0) prev_k_d = is_k;
            case (state_q)
                ST_IDLE: begin
                    if (is_k) begin
                        state_d = ST_SYNC;
                        zeros_d = 2'd1;
                    end
                end
                ST_SYNC: begin
                    if (is_se0) begin
                        state_d = ST_IDLE;
                    end else if (!bit_val) begin
                        if (zeros_q != 2'(SYNC_MIN_ZEROS)) zeros_d = zeros_q + 2'd1;
                    end else if (zeros_q == 2'(SYNC_MIN_ZEROS)) begin
                        state_d   = ST_DATA;
                        active_d  = 1'b1;
                        ones_d    = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (is_se0) begin
                        state_d  = ST_EOP;
                        eop_ok_d = (bit_cnt_q == 3'd0);
                    end else if (ones_q == 3'(STUFF_RUN)) begin
                        // Stuff position: a 0 is dropped, a 1 is a violation
                        if (bit_val) begin
                            state_d    = ST_ERR;
                            error_d    = 1'b1;
                            active_d   = 1'b0;
                            seen_se0_d = 1'b0;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        shift_d   = {bit_val, shift_q[7:1]};
                        ones_d    = bit_val ? ones_q + 3'd1 : 3'd0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(BYTE_W - 1)) begin
                            data_d  = shift_d;
                            valid_d = 1'b1;
                        end
                    end
                end
                ST_EOP: begin
                    if (is_j) begin
                        state_d  = ST_IDLE;
                        eop_d    = eop_ok_q;
                        error_d  = !eop_ok_q;
                        active_d = 1'b0;
                    end
                end
                ST_ERR: begin
                    if (is_se0) begin
                        seen_se0_d = 1'b1;
                    end else if (is_j && seen_se0_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_d == ST_IDLE) prev_k_d = 1'b0;
        end

        // Bus reset abandons everything silently
        if (usb_reset_d) begin
            state_d  = ST_IDLE;
            prev_k_d = 1'b0;
            active_d = 1'b0;
            valid_d  = 1'b0;
            eop_d    = 1'b0;
            error_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev_k_q    <= 1'b0;
            zeros_q     <= '0;
            ones_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            eop_q       <= 1'b0;
            error_q     <= 1'b0;
            eop_ok_q    <= 1'b0;
            seen_se0_q  <= 1'b0;
            se0_cnt_q   <= '0;
            usb_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_k_q    <= prev_k_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
            eop_q       <= eop_d;
            error_q     <= error_d;
            eop_ok_q    <= eop_ok_d;
            seen_se0_q  <= seen_se0_d;
            se0_cnt_q   <= se0_cnt_d;
            usb_reset_q <= usb_reset_d;
        end
    end

    assign bus.line_state = ls;
    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.rx_active  = active_q;
    assign bus.rx_eop     = eop_q;
    assign bus.rx_error   = error_q;
    assign bus.usb_reset  = usb_reset_q;
endmodule

// File: tb/tb_usb_rx_phy.sv
// Scoreboard bench for usb_rx_phy: packets are NRZI/stuff-encoded from
// byte lists, expected events are queued as each packet is issued, and a
// monitor pops and compares whenever the PHY pulses an output.
module tb_usb_rx_phy;
    import usb_rx_phy_pkg::*;

    localparam int unsigned CPB = 16;
    localparam int unsigned RST = 100;
    localparam int EV_VALID = 0;
    localparam int EV_EOP   = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    usb_rx_phy_if bus();

    usb_rx_phy #(.CLKS_PER_BIT(CPB), .RESET_CYCLES(RST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    ev_t        exp_q[$];
    logic [7:0] pkt[$];
    int         checks = 0;
    int         passes = 0;
    int         drift  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_ev(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse must match the head of the expected queue
    always @(negedge clk) begin : monitor
        int   kind;
        ev_t  e;
        if (!reset && (bus.rx_valid || bus.rx_eop || bus.rx_error)) begin
            kind = bus.rx_valid ? EV_VALID : (bus.rx_eop ? EV_EOP : EV_ERR);
            chk("single_pulse", 32'(bus.rx_valid) + 32'(bus.rx_eop) + 32'(bus.rx_error), 1);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: got kind %0d data %0h, expected none", kind, bus.rx_data);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 32'(kind), 32'(e.kind));
                if (e.kind == EV_VALID) chk("rx_data", 32'(bus.rx_data), 32'(e.data));
                chk("rx_active_at_event", 32'(bus.rx_active), (e.kind == EV_VALID) ? 1 : 0);
            end
        end
    end

    // Hold a line level for n clocks; always returns 1 time unit after a posedge
    task automatic drive_sym(input d_port_t v, input int n);
        bus.d_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit period with +-1 clock jitter, cumulative drift kept within one clock
    function automatic int bit_len(input bit jit);
        int j;
        if (!jit) return CPB;
        j = int'($urandom_range(0, 2)) - 1;
        if (drift + j > 1 || drift + j < -1) j = 0;
        drift += j;
        return CPB + j;
    endfunction

    // Send SYNC, nbits data bits of pkt (LSB first), then SE0 and idle J
    task automatic send_packet(input int nbits, input int sync_zeros, input bit stuff_en,
                               input bit jit, input int se0_clks);
        bit         w[$];
        int         ones;
        bit         b;
        bit         k;
        logic [7:0] by;
        ones = 0;
        for (int i = 0; i < sync_zeros; i++) w.push_back(1'b0);
        w.push_back(1'b1);
        for (int i = 0; i < nbits; i++) begin
            by = pkt[i / 8];
            b  = by[i % 8];
            w.push_back(b);
            if (stuff_en) begin
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    w.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        k = 1'b0;
        drift = 0;
        foreach (w[i]) begin
            if (!w[i]) k = !k;
            drive_sym(k ? LS_K : LS_J, bit_len(jit));
        end
        drive_sym(LS_SE0, se0_clks);
        drive_sym(LS_J, 4 * CPB);
    endtask

    // Good packet: every byte then a clean EOP
    task automatic good_packet(input int sync_zeros, input bit jit);
        foreach (pkt[i]) push_ev(EV_VALID, pkt[i]);
        push_ev(EV_EOP, 8'h00);
        send_packet(pkt.size() * 8, sync_zeros, 1'b1, jit, 2 * CPB);
    endtask

    initial begin
        int n;
        bus.d_i = LS_J;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_line_state", 32'(bus.line_state), 32'(LS_J));
        chk("rst_rx_data", 32'(bus.rx_data), 0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_rx_active", 32'(bus.rx_active), 0);
        chk("rst_rx_eop", 32'(bus.rx_eop), 0);
        chk("rst_rx_error", 32'(bus.rx_error), 0);
        chk("rst_usb_reset", 32'(bus.usb_reset), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_sym(LS_J, 4 * CPB);

        // Basic packet, full KJKJKJKK sync
        pkt = '{8'h69};
        good_packet(7, 1'b0);

        // Stuffed 0xFF then 0x00
        pkt = '{8'hFF, 8'h00};
        good_packet(7, 1'b0);

        // Missing stuff bit: 0x00 completes, then seventh 1 is a violation
        pkt = '{8'h00, 8'hFF};
        push_ev(EV_VALID, 8'h00);
        push_ev(EV_ERR, 8'h00);
        send_packet(16, 7, 1'b0, 1'b0, 2 * CPB);

        // SE0 after 4 data bits -> misaligned EOP
        pkt = '{8'hA5};
        push_ev(EV_ERR, 8'h00);
        send_packet(4, 7, 1'b1, 1'b0, 2 * CPB);

        // Short sync with jitter
        pkt = '{8'h3C, 8'hC3, 8'h7E};
        good_packet(3, 1'b1);

        // Bus reset from idle
        bus.d_i = LS_SE0;
        repeat (95) @(posedge clk);
        #4;
        chk("usb_reset_early", 32'(bus.usb_reset), 0);
        repeat (15) @(posedge clk);
        #4;
        chk("usb_reset_set", 32'(bus.usb_reset), 1);
        chk("rx_active_in_bus_reset", 32'(bus.rx_active), 0);
        @(posedge clk);
        #1;
        bus.d_i = LS_J;
        repeat (5) @(posedge clk);
        #4;
        chk("usb_reset_clear", 32'(bus.usb_reset), 0);
        @(posedge clk);
        #1;
        drive_sym(LS_J, 4 * CPB);

        // Bus reset during a packet: abandoned without any pulse
        pkt = '{8'h5A};
        send_packet(4, 7, 1'b1, 1'b0, 150);

        // Packet after bus reset
        pkt = '{8'h81};
        good_packet(5, 1'b0);

        // Async reset mid-byte
        pkt = '{8'hB7};
        drive_sym(LS_K, CPB); drive_sym(LS_J, CPB); drive_sym(LS_K, CPB);
        drive_sym(LS_J, CPB); drive_sym(LS_K, CPB); drive_sym(LS_J, CPB);
        drive_sym(LS_K, CPB); drive_sym(LS_K, CPB);
        drive_sym(LS_J, CPB); drive_sym(LS_K, CPB); drive_sym(LS_J, CPB);
        drive_sym(LS_K, CPB);
        #3;
        chk("rx_active_mid_packet", 32'(bus.rx_active), 1);
        reset   = 1'b1;
        bus.d_i = LS_J;
        #1;
        chk("async_rst_rx_active", 32'(bus.rx_active), 0);
        chk("async_rst_rx_data", 32'(bus.rx_data), 0);
        chk("async_rst_line_state", 32'(bus.line_state), 32'(LS_J));
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive_sym(LS_J, 4 * CPB);
        pkt = '{8'hB7, 8'h01};
        good_packet(7, 1'b0);

        // Randomized packets, biased toward 0xFF to exercise unstuffing
        for (int p = 0; p < 12; p++) begin
            pkt.delete();
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) begin
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            good_packet(int'($urandom_range(3, 7)), 1'($urandom_range(0, 1)));
        end

        drive_sym(LS_J, 8 * CPB);
        chk("events_outstanding", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/usb_rx_phy.md
USB_RX_PHY -- requirements
Module: usb_rx_phy

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per low-speed bit (24 MHz / 1.5 Mbit/s).
REQ-002 Parameter RESET_CYCLES, default 240000: consecutive SE0 clocks that declare bus reset (10 ms at 24 MHz).
REQ-003 clk  input  1  system clock, 24 MHz; the only clock; all outputs change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 d_i  input  d_port_t (2)  raw USB pins, bit 1 = D-, bit 0 = D+; asynchronous to clk.
REQ-006 line_state  output  d_port_t (2)  synchronized pin value.
REQ-007 rx_data  output  8  received byte, LSB first on the wire; valid while rx_valid = 1.
REQ-008 rx_valid  output  1  one-cycle pulse per received byte.
REQ-009 rx_active  output  1  high from SYNC acceptance until EOP or error.
REQ-010 rx_eop  output  1  one-cycle pulse on a good end of packet.
REQ-011 rx_error  output  1  one-cycle pulse on a stuff error or a misaligned EOP.
REQ-012 usb_reset  output  1  level; high while bus reset is detected.

Function
REQ-013 d_i shall pass through a 2-flop synchronizer; line_state is the second flop.
REQ-014 Line-state decoding is low-speed: J = D- high, D+ low; K = D+ high, D- low; SE0 = both low; SE1 = both high (SE1 is treated as an invalid K).
REQ-015 A bit-phase counter (0..CLKS_PER_BIT-1) shall reload to 0 on every line_state change and otherwise wrap; the sample strobe fires at count CLKS_PER_BIT/2-1.
REQ-016 NRZI decode at the strobe: bit = 1 if the sampled J/K equals the previous sample, 0 if it differs; the previous sample is J in IDLE.
REQ-017 FSM states: IDLE, SYNC, DATA, EOP, ERR.
REQ-018 IDLE -> SYNC when a K is sampled.
REQ-019 SYNC accepts at least 3 decoded zeros followed by a 1, then goes to DATA and sets rx_active.
REQ-020 In SYNC, a 1 after fewer than 3 zeros, or an SE0, returns to IDLE with no pulse.
REQ-021 DATA: after 6 consecutive decoded 1s the next bit is a stuff bit and is dropped without being counted.
REQ-022 DATA: if the stuff bit is a 1, rx_error pulses, rx_active drops and the FSM goes to ERR.
REQ-023 The ones run counts across byte boundaries.
REQ-024 DATA: on the 8th non-stuff bit, rx_data updates and rx_valid pulses on the clock after the strobe; the bit count wraps to 0.
REQ-025 DATA: an SE0 at the strobe goes to EOP.
REQ-026 EOP: when the next J is sampled, rx_eop pulses if the bit count was 0 at SE0; otherwise rx_error pulses. rx_active drops on that clock and the FSM returns to IDLE.
REQ-027 ERR: wait for SE0, then J, then go to IDLE with no pulse.
REQ-028 rx_valid and rx_eop never pulse in the same cycle.
REQ-029 A byte whose last bit precedes SE0 pulses rx_valid before rx_eop.
REQ-030 usb_reset sets after RESET_CYCLES consecutive SE0 clocks and clears on the first non-SE0 line_state.
REQ-031 The SE0 counter saturates.
REQ-032 While usb_reset is high, the FSM is forced to IDLE, rx_active is 0, and no pulses are issued.
REQ-033 If usb_reset rises during DATA, the packet is abandoned silently.

Reset
REQ-034 Asynchronous reset shall clear all registers immediately: FSM = IDLE, synchronizer and line_state = J, counters = 0, rx_data = 0, all other outputs = 0.
REQ-035 Reset asserted mid-packet discards the packet with no pulse; the next SYNC is received normally.

Structure
REQ-036 The types package holds d_port_t, the line-state codes J/K/SE0/SE1, and rx_state_t.
REQ-037 One sub-module, usb_rx_dpll: synchronizer, phase counter and strobe, outputs line_state and the sample strobe; usb_rx_phy holds NRZI decode, unstuffing, FSM and reset detection.

Verification
REQ-038 Idle J, then SYNC KJKJKJKK, byte 0x69, SE0 x2 bits, J -> rx_active high, one rx_valid with rx_data = 0x69, then rx_eop; rx_error stays 0.
REQ-039 Byte 0xFF followed by 0x00 with a stuff bit after the 6th 1 -> rx_data 0xFF then 0x00, no error.
REQ-040 Seven consecutive 1s (no stuff bit) -> rx_error pulse, rx_active low, no further rx_valid until a new SYNC.
REQ-041 SE0 after 4 data bits -> rx_error on the next J, no rx_eop.
REQ-042 SYNC with only 4 leading KJ edges, bit period jittered ±1 clock -> packet received correctly.
REQ-043 SE0 held with RESET_CYCLES = 100 -> usb_reset rises after 100 clocks and falls on the first J.
REQ-044 Async reset pulsed mid-byte -> outputs clear that cycle and a following packet decodes correctly.
